bitwise_gate_unit: RTL and testbench

Parametrised, registered two-operand bitwise logic unit with eight selectable operations, including a multi-beat AND-accumulate mode. It generalises the single-bit AND gate to WIDTH-bit operands and adds a valid/ready stream interface with back-pressure and an output register. It sits between stream producers and consumers in the FPGA fabric as the team's standard combinational-logic datapath element.

---
 rtl/bitwise_gate_unit.sv | 121 ++++++++++++
 tb/tb_bitwise_gate_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_gate_unit.sv
// rtl/bitwise_gate_unit.sv - registered WIDTH-bit bitwise logic unit with AND-accumulate bursts
// Stream in, one registered result stage out; op 7 folds beats until in_last.
module bitwise_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_err
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [2:0]       OP_ACC  = 3'd7;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             emit;
  logic [WIDTH-1:0] f_new;
  logic [CNT_W-1:0] cnt_new;
  logic             err_new;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] and_ab;

  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign and_ab   = in_a & in_b;

  always_comb begin
    logic_res = and_ab;
    case (in_op)
      3'd0:    logic_res = and_ab;
      3'd1:    logic_res = in_a | in_b;
      3'd2:    logic_res = in_a ^ in_b;
      3'd3:    logic_res = ~and_ab;
      3'd4:    logic_res = ~(in_a | in_b);
      3'd5:    logic_res = ~(in_a ^ in_b);
      3'd6:    logic_res = ~in_a;
      default: logic_res = and_ab;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    f_new   = '0;
    cnt_new = '0;
    err_new = 1'b0;
    if (accept) begin
      if (in_op == OP_ACC) begin
        if (state_q == IDLE) begin
          acc_d = and_ab;
          cnt_d = CNT_ONE;
        end else begin
          acc_d = acc_q & and_ab;
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        end
        if (in_last) begin
          emit    = 1'b1;
          f_new   = acc_d;
          cnt_new = cnt_d;
          state_d = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end else if (state_q == ACCUM) begin
        // Non-accumulate op mid-burst: report the abort, drop the beat itself.
        emit    = 1'b1;
        err_new = 1'b1;
        cnt_new = cnt_q;
        state_d = IDLE;
      end else begin
        emit    = 1'b1;
        f_new   = logic_res;
        cnt_new = CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_f     <= '0;
      out_cnt   <= '0;
      out_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (emit) begin
        out_valid <= 1'b1;
        out_f     <= f_new;
        out_cnt   <= cnt_new;
        out_err   <= err_new;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_gate_unit.sv
// tb/tb_bitwise_gate_unit.sv - self-checking bench for bitwise_gate_unit
// Three instances share stimulus: 8-bit/CNT_W=8, 1-bit/CNT_W=2, 8-bit/CNT_W=2.
module tb_bitwise_gate_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_err;
  logic [7:0] out_f, out_cnt;
  logic       in_ready1, out_valid1, out_err1;
  logic [0:0] out_f1;
  logic [1:0] out_cnt1;
  logic       in_ready_s, out_valid_s, out_err_s;
  logic [7:0] out_f_s;
  logic [1:0] out_cnt_s;

  always #5 clk = ~clk;

  bitwise_gate_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_cnt(out_cnt), .out_err(out_err));

  bitwise_gate_unit #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a[0:0]), .in_b(in_b[0:0]), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_f(out_f1),
    .out_cnt(out_cnt1), .out_err(out_err1));

  bitwise_gate_unit #(.WIDTH(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_f(out_f_s),
    .out_cnt(out_cnt_s), .out_err(out_err_s));

  int checks = 0;
  int errors = 0;

  // Reference: pending burst kept as a list of per-beat ANDs, output stage as plain state.
  logic [7:0] burst[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_f = '0;
  int         m_cnt = 0;
  logic       m_err = 1'b0;
  logic       m_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  function automatic logic [7:0] op_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a & b;
    endcase
  endfunction

  task automatic model_edge(input logic acc, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic last, input logic rdy);
    logic       emit;
    logic [7:0] f;
    int         c;
    logic       e;
    if (!rst_n) begin
      burst.delete();
      m_valid = 1'b0; m_f = '0; m_cnt = 0; m_err = 1'b0; m_rst = 1'b1;
      return;
    end
    m_rst = 1'b0;
    emit = 1'b0; f = '0; c = 0; e = 1'b0;
    if (acc) begin
      if (op == 3'd7) begin
        burst.push_back(a & b);
        if (last) begin
          f = 8'hFF;
          foreach (burst[i]) f &= burst[i];
          c = burst.size();
          emit = 1'b1;
          burst.delete();
        end
      end else if (burst.size() > 0) begin
        emit = 1'b1; e = 1'b1; f = '0; c = burst.size();
        burst.delete();
      end else begin
        emit = 1'b1; f = op_ref(op, a, b); c = 1;
      end
    end
    if (emit) begin
      m_valid = 1'b1; m_f = f; m_cnt = c; m_err = e;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("out_valid_w1", out_valid1, m_valid);
    chk("out_valid_c2", out_valid_s, m_valid);
    if (m_valid || m_rst) begin
      chk("out_f", out_f, m_f);
      chk("out_cnt", out_cnt, sat(m_cnt, 255));
      chk("out_err", out_err, m_err);
      chk("out_f_w1", out_f1, m_f[0]);
      chk("out_cnt_w1", out_cnt1, sat(m_cnt, 3));
      chk("out_err_w1", out_err1, m_err);
      chk("out_f_c2", out_f_s, m_f);
      chk("out_cnt_c2", out_cnt_s, sat(m_cnt, 3));
      chk("out_err_c2", out_err_s, m_err);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic last, input logic rdy, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    rst_n = 1'b1; in_valid = v; in_op = op; in_a = a; in_b = b; in_last = last; out_ready = rdy;
    #1;
    exp_rdy = !m_valid || rdy;
    chk("in_ready", in_ready, exp_rdy);
    chk("in_ready_w1", in_ready1, exp_rdy);
    chk("in_ready_c2", in_ready_s, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk);
    model_edge(acc, op, a, b, last, rdy);
    #1;
    check_outputs();
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_op = 3'd7; in_a = 8'hFF; in_b = 8'hFF; in_last = 1'b1; out_ready = 1'b1;
    #1;
    chk("in_ready_rst", in_ready, 1'b0);
    @(posedge clk);
    model_edge(1'b0, 3'd0, 8'h0, 8'h0, 1'b0, 1'b1);
    #1;
    check_outputs();
  endtask

  initial begin
    logic       acc;
    logic [7:0] k[7];
    logic [7:0] hold_f;
    logic [7:0] bp_a[4];
    logic [7:0] bp_b[4];
    logic [7:0] got[$];
    int         idx;
    logic       rdy;

    k = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F};

    reset_cycle();
    reset_cycle();

    // Ops 0..6 on the reference pattern.
    for (int op = 0; op < 7; op++) begin
      step(1'b1, 3'(op), 8'hF0, 8'h3C, 1'b0, 1'b1, acc);
      chk("op_const", out_f, k[op]);
    end

    // Truth tables seen through the 1-bit instance.
    for (int op = 0; op < 7; op++)
      for (int ab = 0; ab < 4; ab++)
        step(1'b1, 3'(op), {7'b0, ab[1]}, {7'b0, ab[0]}, 1'b0, 1'b1, acc);

    // Three-beat AND-accumulate burst.
    step(1'b1, 3'd7, 8'hFF, 8'hF7, 1'b0, 1'b1, acc);
    step(1'b1, 3'd7, 8'hEF, 8'hFF, 1'b0, 1'b1, acc);
    step(1'b1, 3'd7, 8'hFE, 8'hFF, 1'b1, 1'b1, acc);
    chk("burst_f", out_f, 8'hE6);
    chk("burst_cnt", out_cnt, 8'd3);

    // Abort: OR beat inside a burst yields one error marker.
    step(1'b1, 3'd7, 8'hFF, 8'hFF, 1'b0, 1'b1, acc);
    step(1'b1, 3'd7, 8'hFF, 8'hFF, 1'b0, 1'b1, acc);
    step(1'b1, 3'd1, 8'h01, 8'h02, 1'b0, 1'b1, acc);
    chk("abort_err", out_err, 1'b1);
    chk("abort_f", out_f, 8'h00);
    chk("abort_cnt", out_cnt, 8'd2);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    chk("abort_no_extra", out_valid, 1'b0);
    step(1'b1, 3'd7, 8'h0F, 8'hFF, 1'b1, 1'b1, acc);
    chk("after_abort_f", out_f, 8'h0F);
    chk("after_abort_cnt", out_cnt, 8'd1);

    // Back-pressure: out_ready low for 3 cycles after the first result.
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 8'($urandom);
      bp_b[i] = 8'($urandom);
    end
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    idx = 0;
    hold_f = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      rdy = !(cyc >= 1 && cyc <= 3);
      if (out_valid && rdy) got.push_back(out_f);
      step(idx < 4, 3'd0, bp_a[idx % 4], bp_b[idx % 4], 1'b0, rdy, acc);
      if (acc) idx++;
      if (cyc == 0) hold_f = bp_a[0] & bp_b[0];
      if (cyc >= 1 && cyc <= 3) chk("bp_stable", out_f, hold_f);
    end
    chk("bp_delivered", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("bp_order", got[i], bp_a[i] & bp_b[i]);

    // Counter saturation on the CNT_W=2 instance.
    for (int i = 0; i < 5; i++)
      step(1'b1, 3'd7, 8'hFF, 8'hFF, i == 4, 1'b1, acc);
    chk("sat_f", out_f_s, 8'hFF);
    chk("sat_cnt", out_cnt_s, 2'd3);
    chk("unsat_cnt", out_cnt, 8'd5);

    // Reset mid-burst, then reset while a result is held.
    step(1'b1, 3'd7, 8'hF0, 8'hFF, 1'b0, 1'b1, acc);
    step(1'b1, 3'd7, 8'h3F, 8'hFF, 1'b0, 1'b1, acc);
    reset_cycle();
    step(1'b1, 3'd2, 8'h5A, 8'h0F, 1'b0, 1'b0, acc);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    reset_cycle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_f", out_f, 8'h00);
    step(1'b1, 3'd7, 8'h3C, 8'hF5, 1'b1, 1'b1, acc);
    chk("post_rst_f", out_f, 8'h34);
    chk("post_rst_cnt", out_cnt, 8'd1);

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        reset_cycle();
      end else begin
        logic [2:0] op;
        op = ($urandom_range(2) == 0) ? 3'($urandom_range(6)) : 3'd7;
        step($urandom_range(3) != 0, op, 8'($urandom | $urandom), 8'($urandom | $urandom),
             $urandom_range(3) == 0, $urandom_range(3) != 0, acc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
